rv_decode_stage: RTL and testbench

Registered instruction-decode pipeline stage for the RV32I/RV64I integer core. Sits between fetch and the register file / execute stages. Extracts register addresses, generates the sign-extended immediate for every base format (I/S/B/U/J), classifies the opcode and flags illegal encodings. Uses a valid/ready handshake with a 2-entry skid buffer, so it sustains one instruction per cycle under backpressure.

---
 rtl/rv_pkg.sv | 64 ++++++
 rtl/rv_imm_gen.sv | 31 +++
 rtl/rv_decode_stage.sv | 161 ++++++++++++++++
 tb/tb_rv_decode_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I/RV64I decode definitions: opcodes, immediate formats,
// opcode classes and the decoded bundle carried through the decode stage.
package rv_pkg;

   localparam int unsigned XLEN_MAX = 64;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned ILEN     = 32;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_type_e;

   typedef enum logic [3:0] {
      CLS_LUI      = 4'd0,
      CLS_AUIPC    = 4'd1,
      CLS_JAL      = 4'd2,
      CLS_JALR     = 4'd3,
      CLS_BRANCH   = 4'd4,
      CLS_LOAD     = 4'd5,
      CLS_STORE    = 4'd6,
      CLS_OP_IMM   = 4'd7,
      CLS_OP       = 4'd8,
      CLS_MISC_MEM = 4'd9,
      CLS_SYSTEM   = 4'd10,
      CLS_ILLEGAL  = 4'd11
   } op_class_e;

   // pc/imm sized for the widest core; narrower instances use the low bits
   typedef struct packed {
      logic [XLEN_MAX-1:0] pc;
      logic [REG_AW-1:0]   rs_a;
      logic [REG_AW-1:0]   rs_b;
      logic [REG_AW-1:0]   rd;
      logic [XLEN_MAX-1:0] imm;
      imm_type_e           imm_type;
      op_class_e           op_class;
      logic                alu_src;
      logic                rd_we;
      logic                illegal;
   } decode_bundle_t;

   // Uncompressed encodings always have the low two bits set
   function automatic logic is_32bit_encoding(input logic [ILEN-1:0] instr);
      return instr[1:0] == 2'b11;
   endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator for the base formats; sign-extends
// from instr[31] to XLEN. Shared with the compressed-instruction expander.
module rv_imm_gen
   import rv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [ILEN-1:0] instr,
   input  imm_type_e       imm_type,
   output logic [XLEN-1:0] imm_c
);

   // Opcode bits never contribute to an immediate
   logic unused_opc;
   assign unused_opc = ^instr[6:0];

   always_comb begin
      imm_c = '0;
      case (imm_type)
         IMM_I:   imm_c = XLEN'($signed(instr[31:20]));
         IMM_S:   imm_c = XLEN'($signed({instr[31:25], instr[11:7]}));
         IMM_B:   imm_c = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                         instr[11:8], 1'b0}));
         IMM_U:   imm_c = XLEN'($signed({instr[31:12], 12'b0}));
         IMM_J:   imm_c = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                         instr[30:21], 1'b0}));
         default: imm_c = '0;
      endcase
   end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered instruction-decode stage with a valid/ready handshake and a
// one-entry skid register behind the output register.
module rv_decode_stage
   import rv_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter bit          RD_X0_WE = 1'b0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [ILEN-1:0]   instr_i,
   input  logic [XLEN-1:0]   pc_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [XLEN-1:0]   pc_o,
   output logic [REG_AW-1:0] rs_addr_a_o,
   output logic [REG_AW-1:0] rs_addr_b_o,
   output logic [REG_AW-1:0] rd_addr_o,
   output logic [XLEN-1:0]   imm_o,
   output logic [2:0]        imm_type_o,
   output logic [3:0]        op_class_o,
   output logic              alu_src_o,
   output logic              rd_we_o,
   output logic              illegal_o
);

   imm_type_e      dec_imm_type;
   op_class_e      dec_class;
   logic           dec_alu_src;
   logic           dec_rd_we;
   logic [XLEN-1:0] dec_imm;
   decode_bundle_t in_bundle;

   decode_bundle_t out_q, out_d;
   decode_bundle_t skid_q, skid_d;
   logic           out_valid_q, out_valid_d;
   logic           skid_valid_q, skid_valid_d;
   logic           accept;
   logic           out_free;

   // Opcode classification; anything unlisted or compressed is illegal
   always_comb begin
      dec_imm_type = IMM_NONE;
      dec_class    = CLS_ILLEGAL;
      dec_alu_src  = 1'b0;
      dec_rd_we    = 1'b0;
      if (is_32bit_encoding(instr_i)) begin
         case (instr_i[6:0])
            OPC_LUI:      begin dec_class = CLS_LUI;      dec_imm_type = IMM_U;
                                dec_alu_src = 1'b1;       dec_rd_we = 1'b1; end
            OPC_AUIPC:    begin dec_class = CLS_AUIPC;    dec_imm_type = IMM_U;
                                dec_alu_src = 1'b1;       dec_rd_we = 1'b1; end
            OPC_JAL:      begin dec_class = CLS_JAL;      dec_imm_type = IMM_J;
                                dec_rd_we = 1'b1; end
            OPC_JALR:     begin dec_class = CLS_JALR;     dec_imm_type = IMM_I;
                                dec_alu_src = 1'b1;       dec_rd_we = 1'b1; end
            OPC_BRANCH:   begin dec_class = CLS_BRANCH;   dec_imm_type = IMM_B; end
            OPC_LOAD:     begin dec_class = CLS_LOAD;     dec_imm_type = IMM_I;
                                dec_alu_src = 1'b1;       dec_rd_we = 1'b1; end
            OPC_STORE:    begin dec_class = CLS_STORE;    dec_imm_type = IMM_S;
                                dec_alu_src = 1'b1; end
            OPC_OP_IMM:   begin dec_class = CLS_OP_IMM;   dec_imm_type = IMM_I;
                                dec_alu_src = 1'b1;       dec_rd_we = 1'b1; end
            OPC_OP:       begin dec_class = CLS_OP;       dec_rd_we = 1'b1; end
            OPC_MISC_MEM: begin dec_class = CLS_MISC_MEM; dec_imm_type = IMM_I; end
            OPC_SYSTEM:   begin dec_class = CLS_SYSTEM;   dec_imm_type = IMM_I; end
            default:      dec_class = CLS_ILLEGAL;
         endcase
      end
      if (instr_i[11:7] == '0 && !RD_X0_WE) begin
         dec_rd_we = 1'b0;
      end
   end

   rv_imm_gen #(
      .XLEN     (XLEN)
   ) u_imm_gen (
      .instr    (instr_i),
      .imm_type (dec_imm_type),
      .imm_c    (dec_imm)
   );

   always_comb begin
      in_bundle          = '0;
      in_bundle.pc       = XLEN_MAX'(pc_i);
      in_bundle.rs_a     = instr_i[19:15];
      in_bundle.rs_b     = instr_i[24:20];
      in_bundle.rd       = instr_i[11:7];
      in_bundle.imm      = XLEN_MAX'($signed(dec_imm));
      in_bundle.imm_type = dec_imm_type;
      in_bundle.op_class = dec_class;
      in_bundle.alu_src  = dec_alu_src;
      in_bundle.rd_we    = dec_rd_we;
      in_bundle.illegal  = (dec_class == CLS_ILLEGAL);
   end

   // Ready depends only on the skid register; reset holds it low
   assign in_ready_o = !skid_valid_q && !rst_i;
   assign accept     = in_valid_i && in_ready_o;
   assign out_free   = !out_valid_q || out_ready_i;

   // Skid drains into the output before any new input; flush beats handshakes
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush_i) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_free) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_d       = in_bundle;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d       = in_bundle;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign pc_o        = out_q.pc[XLEN-1:0];
   assign rs_addr_a_o = out_q.rs_a;
   assign rs_addr_b_o = out_q.rs_b;
   assign rd_addr_o   = out_q.rd;
   assign imm_o       = out_q.imm[XLEN-1:0];
   assign imm_type_o  = out_q.imm_type;
   assign op_class_o  = out_q.op_class;
   assign alu_src_o   = out_q.alu_src;
   assign rd_we_o     = out_q.rd_we;
   assign illegal_o   = out_q.illegal;

   // Bits above XLEN exist only for wider instances
   logic unused_hi;
   assign unused_hi = ^{out_q.pc, out_q.imm};

endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench for rv_decode_stage: XLEN=32 and XLEN=64 instances in
// lockstep, checked against a queue-based reference of the held bundles.
module tb_rv_decode_stage;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rs_a;
      logic [4:0]  rs_b;
      logic [4:0]  rd;
      logic [63:0] imm;
      int          fmt;
      int          cls;
      bit          alu;
      bit          we;
      bit          ill;
   } exp_t;

   typedef struct {
      int cls;
      int fmt;
      bit alu;
      bit we;
   } op_info_t;

   localparam int F_NONE = 0, F_I = 1, F_S = 2, F_B = 3, F_U = 4, F_J = 5;
   localparam int C_ILLEGAL = 11;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic [31:0] instr_i = '0;
   logic [31:0] pc_i = '0;
   logic [63:0] pc64 = '0;
   logic        out_ready_i = 1'b0;

   logic        in_ready_o, out_valid_o, alu_src_o, rd_we_o, illegal_o;
   logic [31:0] pc_o, imm_o;
   logic [4:0]  rs_addr_a_o, rs_addr_b_o, rd_addr_o;
   logic [2:0]  imm_type_o;
   logic [3:0]  op_class_o;

   logic        in_ready64, out_valid64, alu_src64, rd_we64, illegal64;
   logic [63:0] pc_o64, imm_o64;
   logic [4:0]  rs_a64, rs_b64, rd64;
   logic [2:0]  imm_type64;
   logic [3:0]  op_class64;

   int          n_pass = 0;
   int          n_fail = 0;
   exp_t        q[$];
   bit          just_rst = 1'b1;
   op_info_t    op_tab[int];
   int          valid_ops[11] = '{'h37, 'h17, 'h6F, 'h67, 'h63, 'h03, 'h23,
                                  'h13, 'h33, 'h0F, 'h73};

   always #5 clk = ~clk;

   rv_decode_stage #(.XLEN(32), .RD_X0_WE(1'b0)) u_dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .instr_i(instr_i), .pc_i(pc_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .pc_o(pc_o), .rs_addr_a_o(rs_addr_a_o), .rs_addr_b_o(rs_addr_b_o),
      .rd_addr_o(rd_addr_o), .imm_o(imm_o), .imm_type_o(imm_type_o),
      .op_class_o(op_class_o), .alu_src_o(alu_src_o), .rd_we_o(rd_we_o),
      .illegal_o(illegal_o)
   );

   rv_decode_stage #(.XLEN(64), .RD_X0_WE(1'b0)) u_dut64 (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready64),
      .instr_i(instr_i), .pc_i(pc64),
      .out_valid_o(out_valid64), .out_ready_i(out_ready_i),
      .pc_o(pc_o64), .rs_addr_a_o(rs_a64), .rs_addr_b_o(rs_b64),
      .rd_addr_o(rd64), .imm_o(imm_o64), .imm_type_o(imm_type64),
      .op_class_o(op_class64), .alu_src_o(alu_src64), .rd_we_o(rd_we64),
      .illegal_o(illegal64)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference decode straight from the opcode table and immediate formulas
   function automatic exp_t model(input logic [31:0] i, input logic [31:0] p);
      exp_t     e;
      op_info_t info;
      longint   v;
      e.pc   = p;
      e.rs_a = i[19:15];
      e.rs_b = i[24:20];
      e.rd   = i[11:7];
      e.ill  = (i[1:0] != 2'b11) || !op_tab.exists(int'(i[6:0]));
      if (e.ill) begin
         e.cls = C_ILLEGAL; e.fmt = F_NONE; e.alu = 0; e.we = 0; e.imm = '0;
         return e;
      end
      info  = op_tab[int'(i[6:0])];
      e.cls = info.cls;
      e.fmt = info.fmt;
      e.alu = info.alu;
      e.we  = info.we && (i[11:7] != 5'd0);
      v = 0;
      case (info.fmt)
         F_I: v = $signed(i[31:20]);
         F_S: v = $signed({i[31:25], i[11:7]});
         F_B: v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
         F_U: v = $signed({i[31:12], 12'b0});
         F_J: v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
         default: v = 0;
      endcase
      e.imm = 64'(v);
      return e;
   endfunction

   task automatic check_outputs();
      chk("out_valid", 64'(out_valid_o), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready_o), 64'((q.size() < 2) && !rst_i));
      chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
      chk("in_ready64", 64'(in_ready64), 64'((q.size() < 2) && !rst_i));
      if (q.size() > 0) begin
         chk("pc", 64'(pc_o), 64'(q[0].pc));
         chk("pc64", pc_o64, 64'(q[0].pc));
         chk("rs_a", 64'(rs_addr_a_o), 64'(q[0].rs_a));
         chk("rs_b", 64'(rs_addr_b_o), 64'(q[0].rs_b));
         chk("rd", 64'(rd_addr_o), 64'(q[0].rd));
         chk("imm32", 64'(imm_o), 64'(q[0].imm[31:0]));
         chk("imm64", imm_o64, q[0].imm);
         chk("imm_type", 64'(imm_type_o), 64'(q[0].fmt));
         chk("op_class", 64'(op_class_o), 64'(q[0].cls));
         chk("alu_src", 64'(alu_src_o), 64'(q[0].alu));
         chk("rd_we", 64'(rd_we_o), 64'(q[0].we));
         chk("illegal", 64'(illegal_o), 64'(q[0].ill));
         chk("rd_we64", 64'(rd_we64), 64'(q[0].we));
      end
      if (just_rst) begin
         chk("rst_data", {pc_o, imm_o}, 64'd0);
         chk("rst_data64", pc_o64 | imm_o64, 64'd0);
         chk("rst_fields", 64'({rs_addr_a_o, rs_addr_b_o, rd_addr_o, imm_type_o,
                                op_class_o, alu_src_o, rd_we_o, illegal_o}), 64'd0);
      end
   endtask

   // One clock: check current outputs, drive inputs, advance the model
   task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] p,
                       input bit ordy, input bit fl, input bit rs, output bit acc);
      bit drn;
      @(negedge clk);
      check_outputs();
      in_valid_i  = v;
      instr_i     = ins;
      pc_i        = p;
      pc64        = 64'(p);
      out_ready_i = ordy;
      flush_i     = fl;
      rst_i       = rs;
      acc = v && (q.size() < 2) && !fl && !rs;
      drn = (q.size() > 0) && ordy && !fl && !rs;
      @(posedge clk);
      if (rs || fl) q.delete();
      else begin
         if (drn) void'(q.pop_front());
         if (acc) q.push_back(model(ins, p));
      end
      just_rst = rs;
   endtask

   function automatic logic [31:0] gen_instr();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 7) != 0)
         r[6:0] = 7'(valid_ops[$urandom_range(0, 10)]);
      return r;
   endfunction

   initial begin
      bit          acc;
      int          idx;
      logic [31:0] dir[7];
      logic [31:0] cur_i, cur_pc;
      bit          have, v, fl, rs, ordy;

      op_tab['h37] = '{0, F_U, 1, 1};
      op_tab['h17] = '{1, F_U, 1, 1};
      op_tab['h6F] = '{2, F_J, 0, 1};
      op_tab['h67] = '{3, F_I, 1, 1};
      op_tab['h63] = '{4, F_B, 0, 0};
      op_tab['h03] = '{5, F_I, 1, 1};
      op_tab['h23] = '{6, F_S, 1, 0};
      op_tab['h13] = '{7, F_I, 1, 1};
      op_tab['h33] = '{8, F_NONE, 0, 1};
      op_tab['h0F] = '{9, F_I, 0, 0};
      op_tab['h73] = '{10, F_I, 0, 0};

      dir = '{32'hFFF10093, 32'h123452B7, 32'h800002B7, 32'hFE000EE3,
              32'h00322423, 32'h00000000, 32'h0000007F};

      repeat (2) @(posedge clk);

      // Reset held one more cycle, then release
      step(0, '0, '0, 1, 0, 1, acc);

      // Directed formats, full rate
      for (int k = 0; k < 7; k++) step(1, dir[k], 32'h100 + 32'(4 * k), 1, 0, 0, acc);
      step(0, '0, '0, 1, 0, 0, acc);

      // Backpressure: four back-to-back, downstream stalled for three cycles
      idx = 0;
      for (int c = 0; c < 12; c++) begin
         step(idx < 4, (idx < 4) ? dir[idx] : 32'h0, 32'h200 + 32'(4 * idx),
              c >= 3, 0, 0, acc);
         if (acc) idx++;
      end

      // Flush with both entries full and a new input present
      step(1, dir[0], 32'h300, 0, 0, 0, acc);
      step(1, dir[1], 32'h304, 0, 0, 0, acc);
      step(1, dir[3], 32'h308, 0, 1, 0, acc);
      step(0, '0, '0, 1, 0, 0, acc);
      step(1, dir[4], 32'h30C, 1, 0, 0, acc);

      // Reset mid-stream
      step(1, dir[0], 32'h400, 0, 0, 0, acc);
      step(1, dir[1], 32'h404, 0, 0, 0, acc);
      step(1, dir[3], 32'h408, 0, 0, 1, acc);
      step(0, '0, '0, 1, 0, 0, acc);
      step(1, dir[2], 32'h40C, 1, 0, 0, acc);

      // Randomized traffic with occasional flush and reset
      have = 1'b0;
      cur_i = '0;
      cur_pc = '0;
      for (int n = 0; n < 3000; n++) begin
         if (!have) begin
            cur_i  = gen_instr();
            cur_pc = $urandom & 32'hFFFF_FFFC;
            have   = 1'b1;
         end
         v    = ($urandom_range(0, 3) != 0);
         fl   = ($urandom_range(0, 49) == 0);
         rs   = ($urandom_range(0, 99) == 0);
         ordy = ($urandom_range(0, 9) < 7);
         step(v, cur_i, cur_pc, ordy, fl, rs, acc);
         if (acc || (v && (fl || rs))) have = 1'b0;
      end

      repeat (4) step(0, '0, '0, 1, 0, 0, acc);
      @(negedge clk);
      check_outputs();

      $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
      $finish;
   end

endmodule
